// File: rtl/led_anim_sequencer.sv
// LED-matrix animation engine: steps through ROM frames per animation ID, scans rows and
// drives registered row/col lines from a shadow bitmap that only updates at scan boundaries.
module led_anim_sequencer #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned COLS        = 8,
  parameter int unsigned FRAME_W     = 5,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned FRAME_TICKS = 8388608,
  parameter int unsigned ROW_TICKS   = 16384,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          COL_REVERSE = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 anim_start_i,
  input  logic [ID_W-1:0]      anim_id_i,
  input  logic                 loop_en_i,
  input  logic [FRAME_W-1:0]   last_frame_i,
  input  logic                 anim_stop_i,
  input  logic [ROWS*COLS-1:0] frame_dot_i,
  output logic [ID_W-1:0]      anim_id_q_o,
  output logic [FRAME_W-1:0]   frame_idx_o,
  output logic [ROWS-1:0]      row_o,
  output logic [COLS-1:0]      col_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 all_on_o
);

  localparam int unsigned PW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned TW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [PW-1:0]   PrescLast = PW'(FRAME_TICKS - 1);
  localparam logic [TW-1:0]   TickLast  = TW'(ROW_TICKS - 1);
  localparam logic [RW-1:0]   RowLast   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] RowOff    = {ROWS{ACTIVE_LOW}};
  localparam logic [COLS-1:0] ColOff    = {COLS{ACTIVE_LOW}};

  typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   loop_q, loop_d;
  logic [FRAME_W-1:0]     last_q, last_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [RW-1:0]          row_idx_q, row_idx_d;
  logic [ROWS*COLS-1:0]   shadow_q, shadow_d;
  logic [ROWS-1:0]        row_q, row_d;
  logic [COLS-1:0]        col_q, col_d;
  logic                   done_q, done_d;
  logic                   all_on_q, all_on_d;

  logic                   tick_wrap;
  logic                   scan_wrap;
  logic                   frame_tc;
  logic [COLS-1:0]        slice;
  logic [COLS-1:0]        col_lit;
  logic [ROWS-1:0]        row_lit;

  always_comb begin
    tick_wrap = (tick_q == TickLast);
    scan_wrap = tick_wrap && (row_idx_q == RowLast);
    frame_tc  = (state_q == StPlay) && (presc_q == PrescLast);

    state_d   = state_q;
    id_d      = id_q;
    loop_d    = loop_q;
    last_d    = last_q;
    frame_d   = frame_q;
    presc_d   = '0;
    done_d    = 1'b0;
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    row_idx_d = row_idx_q;
    if (tick_wrap) begin
      row_idx_d = (row_idx_q == RowLast) ? '0 : row_idx_q + 1'b1;
    end
    // Bitmap swaps only between full scans so a frame change never tears.
    shadow_d  = (state_q == StIdle) ? '0 : (scan_wrap ? frame_dot_i : shadow_q);

    if (anim_start_i) begin
      state_d   = StPlay;
      id_d      = anim_id_i;
      loop_d    = loop_en_i;
      last_d    = last_frame_i;
      frame_d   = '0;
      tick_d    = '0;
      row_idx_d = '0;
    end else if (anim_stop_i) begin
      state_d = StIdle;
    end else if (state_q == StPlay) begin
      presc_d = frame_tc ? '0 : presc_q + 1'b1;
      if (frame_tc) begin
        if (frame_q < last_q) begin
          frame_d = frame_q + 1'b1;
        end else if (loop_q) begin
          frame_d = '0;
        end else begin
          state_d = StHold;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_idx_q == RW'(r)) begin
        slice = shadow_q[(ROWS - r) * COLS - 1 -: COLS];
      end
    end
    col_lit = slice;
    if (COL_REVERSE) begin
      for (int c = 0; c < COLS; c++) begin
        col_lit[c] = slice[COLS - 1 - c];
      end
    end
    row_lit            = '0;
    row_lit[row_idx_q] = 1'b1;
    row_d              = row_lit ^ RowOff;
    col_d              = col_lit ^ ColOff;
    all_on_d           = (&shadow_q) && (state_q != StIdle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      id_q      <= '0;
      loop_q    <= 1'b0;
      last_q    <= '0;
      frame_q   <= '0;
      presc_q   <= '0;
      tick_q    <= '0;
      row_idx_q <= '0;
      shadow_q  <= '0;
      row_q     <= RowOff;
      col_q     <= ColOff;
      done_q    <= 1'b0;
      all_on_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      loop_q    <= loop_d;
      last_q    <= last_d;
      frame_q   <= frame_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      row_idx_q <= row_idx_d;
      shadow_q  <= shadow_d;
      row_q     <= row_d;
      col_q     <= col_d;
      done_q    <= done_d;
      all_on_q  <= all_on_d;
    end
  end

  assign anim_id_q_o = id_q;
  assign frame_idx_o = frame_q;
  assign row_o       = row_q;
  assign col_o       = col_q;
  assign busy_o      = (state_q == StPlay);
  assign done_o      = done_q;
  assign all_on_o    = all_on_q;

endmodule

// File: tb/tb_led_anim_sequencer.sv
// Scoreboard bench for led_anim_sequencer: a time-based reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_led_anim_sequencer;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int FT   = 64;
  localparam int RT   = 2;
  localparam int S    = ROWS * RT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        anim_start = 1'b0;
  logic [1:0]  anim_id = '0;
  logic        loop_en = 1'b0;
  logic [4:0]  last_frame = '0;
  logic        anim_stop = 1'b0;
  logic [63:0] frame_dot;
  logic [1:0]  anim_id_q;
  logic [4:0]  frame_idx;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        busy;
  logic        done;
  logic        all_on;

  logic        ovr_en = 1'b0;
  logic [63:0] ovr_val = '0;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_fn(input logic [1:0] id, input logic [4:0] fr);
    logic [63:0] h;
    if (id == 2'd0 && fr == 5'd0) return '1;
    if (id == 2'd3 && fr == 5'd0) return {8'hFF, 56'h0};
    h = 64'h9E3779B97F4A7C15 * {57'd0, id, fr} + 64'h0123456789ABCDEF;
    return h ^ (h >> 29);
  endfunction

  assign frame_dot = ovr_en ? ovr_val : rom_fn(anim_id_q, frame_idx);

  led_anim_sequencer #(
    .ROWS(8), .COLS(8), .FRAME_W(5), .ID_W(2), .FRAME_TICKS(FT), .ROW_TICKS(RT),
    .ACTIVE_LOW(1'b1), .COL_REVERSE(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .anim_start_i(anim_start), .anim_id_i(anim_id),
    .loop_en_i(loop_en), .last_frame_i(last_frame), .anim_stop_i(anim_stop),
    .frame_dot_i(frame_dot), .anim_id_q_o(anim_id_q), .frame_idx_o(frame_idx), .row_o(row),
    .col_o(col), .busy_o(busy), .done_o(done), .all_on_o(all_on)
  );

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [4:0] frame;
    logic [1:0] id;
    logic       busy;
    logic       done;
    logic       all_on;
  } exp_t;

  exp_t exp_q[$];

  // Model: m_n counts edges since reset or the last start; everything derives from it.
  int          m_n;
  bit          m_active;
  logic [1:0]  m_id;
  bit          m_loop;
  int          m_last;
  int          m_frozen;
  logic [63:0] m_shadow;

  function automatic int st_of();  // 0 idle, 1 play, 2 hold
    int m;
    if (!m_active) return 0;
    m = m_n / FT;
    return (m_loop || m <= m_last) ? 1 : 2;
  endfunction

  function automatic int frame_of();
    int m;
    if (!m_active) return m_frozen;
    m = m_n / FT;
    if (m_loop) return m % (m_last + 1);
    return (m <= m_last) ? m : m_last;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int          old_st, old_fr, r_old;
    logic [63:0] rom_old;
    logic [4:0]  fr5;
    exp_t        e;
    if (reset) begin
      m_n = 0; m_active = 0; m_id = '0; m_loop = 0; m_last = 0; m_frozen = 0;
      m_shadow = '0;
      exp_q.delete();
    end else begin
      old_st  = st_of();
      old_fr  = frame_of();
      fr5     = old_fr[4:0];
      rom_old = ovr_en ? ovr_val : rom_fn(m_id, fr5);
      r_old   = (m_n / RT) % ROWS;
      e.row   = ~(8'h01 << r_old);
      for (int c = 0; c < COLS; c++) e.col[c] = ~m_shadow[(ROWS - r_old) * COLS - 1 - c];
      e.all_on = (&m_shadow) && (old_st != 0);
      if (old_st == 0) m_shadow = '0;
      else if ((m_n % S) == S - 1) m_shadow = rom_old;
      if (anim_start) begin
        m_active = 1; m_id = anim_id; m_loop = loop_en; m_last = int'(last_frame); m_n = 0;
      end else begin
        if (anim_stop && m_active) begin
          m_frozen = old_fr;
          m_active = 0;
        end
        m_n++;
      end
      e.done  = m_active && !m_loop && (m_n == (m_last + 1) * FT);
      e.busy  = (st_of() == 1);
      e.frame = 5'(frame_of());
      e.id    = m_id;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{row: row, col: col, frame: frame_idx, id: anim_id_q, busy: busy, done: done,
            all_on: all_on};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got row=%h col=%h fr=%0d id=%0d busy=%b done=%b all_on=%b exp row=%h col=%h fr=%0d id=%0d busy=%b done=%b all_on=%b",
                 $time, a.row, a.col, a.frame, a.id, a.busy, a.done, a.all_on,
                 e.row, e.col, e.frame, e.id, e.busy, e.done, e.all_on);
      end
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] id, input logic [4:0] lf, input logic lp,
                             input logic stop);
    anim_start = 1'b1; anim_stop = stop; anim_id = id; last_frame = lf; loop_en = lp;
    @(negedge clk);
    anim_start = 1'b0; anim_stop = 1'b0;
    anim_id = 2'($urandom); last_frame = 5'($urandom); loop_en = 1'($urandom);
  endtask

  task automatic pulse_stop();
    anim_stop = 1'b1;
    @(negedge clk);
    anim_stop = 1'b0;
  endtask

  task automatic wait_row(input int r, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (row === ~(8'h01 << r)) ok = 1;
    end
    if (!ok) begin
      failures++;
      $display("FAIL wait_row%0d got=timeout exp=row seen", r);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          ok;
    logic [7:0]  exp_col;
    int          k;
    #1 reset = 1'b1;
    #2;
    check("reset_row", 64'(row), 64'hFF);
    check("reset_col", 64'(col), 64'hFF);
    check("reset_busy", 64'(busy), 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Play-once: frames 0..3 then hold.
    done_seen = 0;
    pulse_start(2'd1, 5'd3, 1'b0, 1'b0);
    check("once_busy", 64'(busy), 64'h1);
    repeat (4 * FT + 1000) @(negedge clk);
    check("once_done_count", 64'(done_seen), 64'd1);
    check("once_hold_frame", 64'(frame_idx), 64'd3);
    check("once_busy_low", 64'(busy), 64'h0);

    // Loop: done never fires.
    done_seen = 0;
    pulse_start(2'd2, 5'd2, 1'b1, 1'b0);
    repeat (6 * FT + 20) @(negedge clk);
    check("loop_no_done", 64'(done_seen), 64'd0);
    check("loop_busy", 64'(busy), 64'h1);

    // Top row fully lit, rest dark.
    pulse_start(2'd3, 5'd0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    wait_row(0, ok);
    if (ok) check("ff00_row0_col", 64'(col), 64'h00);
    wait_row(1, ok);
    if (ok) check("ff00_row1_col", 64'(col), 64'hFF);

    // All-ones frame then stop.
    pulse_start(2'd0, 5'd0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("all_on_set", 64'(all_on), 64'h1);
    pulse_stop();
    repeat (4) @(negedge clk);
    check("all_on_clear", 64'(all_on), 64'h0);
    check("stop_col_dark", 64'(col), 64'hFF);

    // Bitmap swap mid-scan.
    pulse_start(2'd1, 5'd3, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    wait_row(3, ok);
    ovr_val = {$urandom, $urandom};
    ovr_en  = 1'b1;
    wait_row(0, ok);
    for (int c = 0; c < 8; c++) exp_col[c] = ~ovr_val[63 - c];
    if (ok) check("swap_row0_col", 64'(col), 64'(exp_col));
    repeat (40) @(negedge clk);
    ovr_en = 1'b0;

    // Start and stop together in HOLD; then same-ID restart mid-play.
    pulse_start(2'd1, 5'd1, 1'b0, 1'b0);
    repeat (2 * FT + 10) @(negedge clk);
    check("hold_reached", 64'(busy), 64'h0);
    pulse_start(2'd2, 5'd1, 1'b0, 1'b1);
    check("startstop_busy", 64'(busy), 64'h1);
    check("startstop_frame", 64'(frame_idx), 64'd0);
    repeat (100) @(negedge clk);
    check("pre_restart_frame", 64'(frame_idx), 64'd1);
    pulse_start(2'd2, 5'd1, 1'b0, 1'b0);
    check("restart_frame", 64'(frame_idx), 64'd0);
    repeat (FT - 2) @(negedge clk);
    check("restart_presc_cleared", 64'(frame_idx), 64'd0);
    repeat (2) @(negedge clk);
    check("restart_next_frame", 64'(frame_idx), 64'd1);

    // Random start/stop traffic.
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 3);
      if (k == 2) pulse_stop();
      else pulse_start(2'($urandom), 5'($urandom_range(0, 4)), 1'($urandom), k == 3);
      repeat ($urandom_range(1, 300)) @(negedge clk);
    end

    // Asynchronous reset mid-scan.
    pulse_start(2'd2, 5'd3, 1'b1, 1'b0);
    repeat (37) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_row", 64'(row), 64'hFF);
    check("areset_col", 64'(col), 64'hFF);
    check("areset_frame", 64'(frame_idx), 64'd0);
    check("areset_busy", 64'(busy), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_x_after_reset", 64'($isunknown({row, col, frame_idx, anim_id_q, busy, done, all_on})),
          64'h0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
